// File: rtl/dm_banked_ram_pkg.sv
// rtl/dm_banked_ram_pkg.sv - shared constants, state enum and byte-enable helpers for dm_banked_ram
package dm_pkg;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_BYTE1   = 4'b0010;
    localparam logic [3:0] BE_BYTE2   = 4'b0100;
    localparam logic [3:0] BE_BYTE3   = 4'b1000;

    typedef enum logic {INIT, RUN} dm_state_e;

    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            BE_WORD, BE_HALF_LO, BE_HALF_HI,
            BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3: be_legal = 1'b1;
            default:                                be_legal = 1'b0;
        endcase
    endfunction

    // Producer aligns bytes/halves at bit 0; replicate so every enabled lane sees its data.
    function automatic logic [31:0] lane_data(input logic [3:0] be, input logic [31:0] wdata);
        case (be)
            BE_WORD:                lane_data = wdata;
            BE_HALF_LO, BE_HALF_HI: lane_data = {2{wdata[15:0]}};
            default:                lane_data = {4{wdata[7:0]}};
        endcase
    endfunction

endpackage

// File: rtl/dm_banked_ram_if.sv
// rtl/dm_banked_ram_if.sv - request/response bus between the MEM stage and dm_banked_ram
interface dm_banked_ram_if;
    logic        irq;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output irq, req, we, addr, wdata, be, pc,
                    input  ready, rvalid, rdata, err);
    modport slave  (input  irq, req, we, addr, wdata, be, pc,
                    output ready, rvalid, rdata, err);
endinterface

// File: rtl/dm_lane_ram.sv
// rtl/dm_lane_ram.sv - 32-bit single-port RAM with byte-lane write enables and registered read
module dm_lane_ram #(
    parameter  int DEPTH_WORDS = 4096,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic [3:0]       wen,
    input  logic [31:0]      wdata,
    input  logic             re,
    output logic [31:0]      rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wen[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
        end
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/dm_banked_ram.sv
// rtl/dm_banked_ram.sv - windowed data RAM with zero-fill sweep, irq write blocking and fault flagging
// Optional store logging is compiled in when DM_WRITE_LOG_EN is defined.
module dm_banked_ram
    import dm_pkg::*;
#(
    parameter  int          DEPTH_WORDS = 4096,
    parameter  logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter  logic [31:0] LIMIT_ADDR  = 32'h0000_2fff,
    localparam int          IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    dm_banked_ram_if.slave   bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [31:0]      SPAN     = LIMIT_ADDR - BASE_ADDR;

    dm_state_e        state;
    logic [IDX_W-1:0] cnt;
    logic             zero_q;
    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic             in_win, legal, acc, ld, wr_ok;
    logic [IDX_W-1:0] ram_addr;
    logic [3:0]       ram_wen;
    logic [31:0]      ram_wd, ram_q;

    assign off    = bus.addr - BASE_ADDR;
    assign idx    = off[IDX_W+1:2];
    assign in_win = (bus.addr >= BASE_ADDR) && (off <= SPAN);
    assign legal  = be_legal(bus.be);
    assign acc    = bus.ready && bus.req;
    assign ld     = acc && !bus.we;
    assign wr_ok  = acc && bus.we && !bus.irq && in_win && legal;

    // The sweep borrows the single RAM port; requests are not accepted until RUN.
    assign ram_addr = (state == INIT) ? cnt : idx;
    assign ram_wen  = (state == INIT) ? 4'hf : (wr_ok ? bus.be : 4'h0);
    assign ram_wd   = (state == INIT) ? 32'h0 : lane_data(bus.be, bus.wdata);

    dm_lane_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .wen   (ram_wen),
        .wdata (ram_wd),
        .re    (ld && in_win),
        .rdata (ram_q)
    );

    // The RAM output only moves on an in-window load, so masking it holds rdata between loads.
    assign bus.rdata = zero_q ? 32'h0 : ram_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= INIT;
            cnt        <= '0;
            bus.ready  <= 1'b0;
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    cnt        <= cnt + IDX_W'(1);
                    bus.rvalid <= 1'b0;
                    bus.err    <= 1'b0;
                    if (cnt == LAST_IDX) begin
                        state     <= RUN;
                        bus.ready <= 1'b1;
                    end
                end
                RUN: begin
                    bus.rvalid <= ld;
                    bus.err    <= acc && (bus.we ? (!bus.irq && !(in_win && legal)) : !in_win);
                    if (ld) zero_q <= !in_win;
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef DM_WRITE_LOG_EN
    logic [31:0] log_word;

    always @(posedge clk) begin
        if (reset && wr_ok) begin
            for (int k = 0; k < 4; k++) begin
                log_word[8*k +: 8] = ram_wen[k] ? ram_wd[8*k +: 8] : u_ram.mem[ram_addr][8*k +: 8];
            end
            $display("%d@%h: *%h <= %h", $time, bus.pc, {bus.addr[31:2], 2'b00}, log_word);
        end
    end
`else
`endif

endmodule
